// File: rtl/trigger_network_sync_pkg.sv
// Shared types for the network-side trigger controller.
package trigger_network_sync_pkg;

    typedef enum logic [1:0] {
        NET_IDLE,
        NET_START,
        NET_RUN,
        NET_DONE
    } net_state_t;

    localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/trigger_network_sync_if.sv
// Host handshake and actor-trigger bundle for trigger_network_sync.
// TRIGGER_NETWORK_SYNC_STATS_EN adds the run_cycles/sleep_cycles statistics outputs.
interface trigger_network_sync_if #(
    parameter int unsigned NUM_ACTORS = 4,
    parameter int unsigned ROUND_W    = 32
);
    import trigger_network_sync_pkg::*;

    logic                  ap_start;
    logic                  ap_done;
    logic                  ap_ready;
    logic                  ap_idle;
    logic [NUM_ACTORS-1:0] trig_start;
    logic [NUM_ACTORS-1:0] trig_idle;
    logic [NUM_ACTORS-1:0] trig_sleep;
    logic [NUM_ACTORS-1:0] trig_sync_exec;
    logic [NUM_ACTORS-1:0] trig_sync_wait;
    logic [NUM_ACTORS-1:0] trig_waited;
    logic                  all_sleep;
    logic                  all_sync;
    logic                  all_sync_wait;
    logic [NUM_ACTORS-1:0] all_waited;
    logic [ROUND_W-1:0]    sync_rounds;
`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
    logic [STATS_W-1:0]    run_cycles;
    logic [STATS_W-1:0]    sleep_cycles;

    modport master (
        input  ap_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited,
        output ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
        output all_waited, sync_rounds, run_cycles, sleep_cycles
    );
    modport slave (
        output ap_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited,
        input  ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
        input  all_waited, sync_rounds, run_cycles, sleep_cycles
    );
`else
    modport master (
        input  ap_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited,
        output ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
        output all_waited, sync_rounds
    );
    modport slave (
        output ap_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited,
        input  ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
        input  all_waited, sync_rounds
    );
`endif

endinterface

// File: rtl/trigger_network_sync_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/trigger_network_sync.sv
// Network controller: fans ap_start out to actor triggers, reduces their status into
// zero-latency qualifiers and reports completion. Optional TRIGGER_NETWORK_SYNC_STATS_EN.
module trigger_network_sync
    import trigger_network_sync_pkg::*;
#(
    parameter int unsigned NUM_ACTORS = 4,
    parameter int unsigned ROUND_W    = 32
) (
    input logic                    ap_clk,
    input logic                    ap_rst_n,
    trigger_network_sync_if.master bus
);

    net_state_t            state_q;
    logic                  ap_idle_q;
    logic                  ap_done_q;
    logic [NUM_ACTORS-1:0] trig_start_q;
    logic                  all_sync_q;

    logic                  all_sleep;
    logic                  all_sync;
    logic                  all_sync_wait;
    logic [NUM_ACTORS-1:0] all_waited;
    logic [NUM_ACTORS-1:0] waited_masked;

    logic                  start_clr;
    logic                  in_run;
    logic                  round_inc;
    logic [ROUND_W-1:0]    sync_rounds;

    // Qualifiers ignore controller state so triggers stay consistent across reset release.
    assign all_sleep     = &bus.trig_sleep;
    assign all_sync      = &(bus.trig_sync_exec | bus.trig_sync_wait);
    assign all_sync_wait = &bus.trig_sync_wait;

    always_comb begin
        all_waited    = '0;
        waited_masked = '0;
        for (int i = 0; i < NUM_ACTORS; i++) begin
            waited_masked    = bus.trig_waited;
            waited_masked[i] = 1'b1;
            all_waited[i]    = &waited_masked;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= NET_IDLE;
            ap_idle_q    <= 1'b1;
            ap_done_q    <= 1'b0;
            trig_start_q <= '0;
            all_sync_q   <= 1'b0;
        end else begin
            all_sync_q   <= all_sync;
            ap_done_q    <= 1'b0;
            trig_start_q <= '0;
            case (state_q)
                NET_IDLE: begin
                    if (bus.ap_start) begin
                        state_q      <= NET_START;
                        ap_idle_q    <= 1'b0;
                        trig_start_q <= '1;
                    end
                end
                NET_START: state_q <= NET_RUN;
                NET_RUN: begin
                    if (&bus.trig_idle) begin
                        state_q   <= NET_DONE;
                        ap_done_q <= 1'b1;
                    end
                end
                NET_DONE: begin
                    state_q   <= NET_IDLE;
                    ap_idle_q <= 1'b1;
                end
                default: begin
                    state_q   <= NET_IDLE;
                    ap_idle_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_clr = (state_q == NET_IDLE) && bus.ap_start;
    assign in_run    = (state_q == NET_RUN);
    assign round_inc = in_run && all_sync && !all_sync_q;

    sat_counter #(.W(ROUND_W)) u_sync_rounds (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .clr   (start_clr),
        .inc   (round_inc),
        .q     (sync_rounds)
    );

`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
    logic [STATS_W-1:0] run_cycles;
    logic [STATS_W-1:0] sleep_cycles;

    sat_counter #(.W(STATS_W)) u_run_cycles (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .clr   (start_clr),
        .inc   (in_run),
        .q     (run_cycles)
    );

    sat_counter #(.W(STATS_W)) u_sleep_cycles (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .clr   (start_clr),
        .inc   (in_run && all_sleep),
        .q     (sleep_cycles)
    );

    assign bus.run_cycles   = run_cycles;
    assign bus.sleep_cycles = sleep_cycles;
`endif

    assign bus.ap_done       = ap_done_q;
    assign bus.ap_ready      = ap_done_q;
    assign bus.ap_idle       = ap_idle_q;
    assign bus.trig_start    = trig_start_q;
    assign bus.all_sleep     = all_sleep;
    assign bus.all_sync      = all_sync;
    assign bus.all_sync_wait = all_sync_wait;
    assign bus.all_waited    = all_waited;
    assign bus.sync_rounds   = sync_rounds;

endmodule

// File: tb/tb_trigger_network_sync.sv
// Randomized self-checking bench for trigger_network_sync (NUM_ACTORS=4, ROUND_W=2).
module tb_trigger_network_sync;

    localparam int unsigned NA   = 4;
    localparam int unsigned RW   = 2;
    localparam int          MAXR = (1 << RW) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Reference model state: rounds, run/sleep cycle counts.
    int   m_rounds;
    int   m_run_cnt;
    int   m_sleep_cnt;
    bit   m_prev;
    bit   m_in_run;
    bit   m_clr;

    trigger_network_sync_if #(.NUM_ACTORS(NA), .ROUND_W(RW)) bus ();

    trigger_network_sync #(.NUM_ACTORS(NA), .ROUND_W(RW)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit every_actor_synced();
        int n = 0;
        for (int i = 0; i < NA; i++) begin
            if (bus.trig_sync_exec[i] || bus.trig_sync_wait[i]) n++;
        end
        return n == NA;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit cur;
        if (!rst_n) begin
            m_rounds = 0; m_run_cnt = 0; m_sleep_cnt = 0; m_prev = 0;
        end else begin
            cur = every_actor_synced();
            if (m_clr) begin
                m_rounds = 0; m_run_cnt = 0; m_sleep_cnt = 0;
            end else if (m_in_run) begin
                if (cur && !m_prev && m_rounds < MAXR) m_rounds++;
                m_run_cnt++;
                if (bus.trig_sleep == {NA{1'b1}}) m_sleep_cnt++;
            end
            m_prev = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.trig_idle      = '1;
        bus.trig_sleep     = '0;
        bus.trig_sync_exec = '0;
        bus.trig_sync_wait = '1;
        bus.trig_waited    = '0;
    endtask

    task automatic drive_sync(input bit s);
        logic [NA-1:0] e, w;
        int k;
        e = NA'($urandom);
        w = NA'($urandom);
        if (s) begin
            w = w | ~e;
        end else begin
            k = $urandom_range(0, NA - 1);
            e[k] = 1'b0;
            w[k] = 1'b0;
        end
        bus.trig_sync_exec = e;
        bus.trig_sync_wait = w;
    endtask

    function automatic logic [NA-1:0] some_low();
        logic [NA-1:0] v;
        int k;
        v = NA'($urandom);
        k = $urandom_range(0, NA - 1);
        v[k] = 1'b0;
        return v;
    endfunction

    task automatic do_start(input bit hold);
        bus.ap_start = 1'b1;
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        if (!hold) bus.ap_start = 1'b0;
        checks++;
        if (bus.trig_start !== {NA{1'b1}}) begin
            failures++; $display("FAIL start_pulse trig_start=%b want=%b", bus.trig_start, {NA{1'b1}});
        end
        checks++;
        if (bus.ap_idle !== 1'b0 || bus.ap_done !== 1'b0) begin
            failures++; $display("FAIL start_idle ap_idle=%b ap_done=%b want 0/0", bus.ap_idle, bus.ap_done);
        end
        checks++;
        if (bus.sync_rounds !== RW'(m_rounds)) begin
            failures++; $display("FAIL start_clear sync_rounds=%0d want=%0d", bus.sync_rounds, m_rounds);
        end
        bus.trig_idle      = some_low();
        bus.trig_sync_wait = '0;
        tick();
        m_in_run = 1'b1;
        checks++;
        if (bus.trig_start !== '0 || bus.ap_idle !== 1'b0) begin
            failures++; $display("FAIL run_entry trig_start=%b ap_idle=%b want 0/0", bus.trig_start, bus.ap_idle);
        end
    endtask

    task automatic run_cycle(input bit s, input bit slp, input bit fin);
        drive_sync(s);
        bus.trig_sleep  = slp ? {NA{1'b1}} : some_low();
        bus.trig_idle   = fin ? {NA{1'b1}} : some_low();
        bus.trig_waited = NA'($urandom);
        #1;
        checks++;
        if (bus.all_sync !== s || bus.all_sleep !== slp) begin
            failures++;
            $display("FAIL run_qual all_sync=%b want=%b all_sleep=%b want=%b", bus.all_sync, s, bus.all_sleep, slp);
        end
        tick();
        if (fin) m_in_run = 1'b0;
        checks++;
        if (bus.ap_done !== fin || bus.ap_ready !== fin || bus.ap_idle !== 1'b0) begin
            failures++;
            $display("FAIL run_done ap_done=%b ap_ready=%b ap_idle=%b want %b/%b/0", bus.ap_done, bus.ap_ready,
                     bus.ap_idle, fin, fin);
        end
        checks++;
        if (bus.sync_rounds !== RW'(m_rounds)) begin
            failures++; $display("FAIL run_rounds sync_rounds=%0d want=%0d", bus.sync_rounds, m_rounds);
        end
    endtask

    task automatic finish_run();
        idle_inputs();
        tick();
        checks++;
        if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0 || bus.ap_idle !== 1'b1 || bus.trig_start !== '0) begin
            failures++;
            $display("FAIL post_done ap_done=%b ap_ready=%b ap_idle=%b trig_start=%b want 0/0/1/0", bus.ap_done,
                     bus.ap_ready, bus.ap_idle, bus.trig_start);
        end
        checks++;
        if (bus.sync_rounds !== RW'(m_rounds)) begin
            failures++; $display("FAIL rounds_hold sync_rounds=%0d want=%0d", bus.sync_rounds, m_rounds);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ap_idle=%b ap_done=%b ap_ready=%b want 1/0/0", bus.ap_idle, bus.ap_done, bus.ap_ready);
        end
        checks++;
        if (bus.trig_start !== '0 || bus.sync_rounds !== '0) begin
            failures++;
            $display("FAIL reset_regs trig_start=%b sync_rounds=%0d want 0/0", bus.trig_start, bus.sync_rounds);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_qualifiers();
        logic [NA-1:0] exp_w;
        bit ok;
        for (int n = 0; n < 24; n++) begin
            bus.trig_sleep     = (n == 1) ? 4'b1111 : NA'($urandom);
            bus.trig_sync_exec = NA'($urandom);
            bus.trig_sync_wait = (n == 2) ? 4'b1111 : NA'($urandom);
            bus.trig_waited    = (n == 0) ? 4'b1110 : NA'($urandom);
            for (int i = 0; i < NA; i++) begin
                ok = 1'b1;
                for (int j = 0; j < NA; j++) begin
                    if (j != i && !bus.trig_waited[j]) ok = 1'b0;
                end
                exp_w[i] = ok;
            end
            #2;
            checks++;
            if (bus.all_waited !== exp_w) begin
                failures++; $display("FAIL all_waited in=%b got=%b want=%b", bus.trig_waited, bus.all_waited, exp_w);
            end
            checks++;
            if (bus.all_sleep !== (bus.trig_sleep == {NA{1'b1}})) begin
                failures++; $display("FAIL all_sleep in=%b got=%b", bus.trig_sleep, bus.all_sleep);
            end
            checks++;
            if (bus.all_sync !== every_actor_synced()) begin
                failures++; $display("FAIL all_sync got=%b want=%b", bus.all_sync, every_actor_synced());
            end
            checks++;
            if (bus.all_sync_wait !== (bus.trig_sync_wait == {NA{1'b1}})) begin
                failures++; $display("FAIL all_sync_wait in=%b got=%b", bus.trig_sync_wait, bus.all_sync_wait);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_start_and_rounds();
        bit pat [5] = '{0, 1, 1, 0, 1};
        do_start(1'b0);
        foreach (pat[i]) run_cycle(pat[i], 1'b0, 1'b0);
        checks++;
        if (bus.sync_rounds !== RW'(2)) begin
            failures++; $display("FAIL rounds_pattern sync_rounds=%0d want=2", bus.sync_rounds);
        end
        for (int i = 0; i < 6; i++) run_cycle(i[0], 1'b0, 1'b0);
        checks++;
        if (bus.sync_rounds !== RW'(MAXR)) begin
            failures++; $display("FAIL rounds_saturate sync_rounds=%0d want=%0d", bus.sync_rounds, MAXR);
        end
        // Triggers settle in sync_wait before going idle.
        bus.trig_sync_exec = '0;
        bus.trig_sync_wait = '1;
        #1;
        checks++;
        if (bus.all_sync_wait !== 1'b1) begin
            failures++; $display("FAIL completion_wait all_sync_wait=%b want=1", bus.all_sync_wait);
        end
        tick();
        run_cycle(1'b1, 1'b0, 1'b1);
        finish_run();
    endtask

    task automatic test_back_to_back();
        do_start(1'b1);
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        idle_inputs();
        bus.trig_sync_wait = '0;
        m_clr = 1'b0;
        tick();
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.trig_start !== '0 || bus.sync_rounds !== RW'(m_rounds)) begin
            failures++;
            $display("FAIL b2b_gap ap_idle=%b trig_start=%b sync_rounds=%0d want 1/0/%0d", bus.ap_idle,
                     bus.trig_start, bus.sync_rounds, m_rounds);
        end
        do_start(1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        finish_run();
    endtask

    task automatic test_random_runs();
        int len;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(2, 12);
            do_start(1'($urandom));
            for (int c = 0; c < len; c++) begin
                run_cycle(1'($urandom), 1'($urandom), c == len - 1);
            end
            bus.ap_start = 1'b0;
            finish_run();
        end
    endtask

`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
    task automatic test_stats();
        do_start(1'b0);
        for (int c = 0; c < 10; c++) begin
            run_cycle(1'($urandom), (c % 3) == 1, c == 9);
        end
        checks++;
        if (bus.run_cycles !== 32'(m_run_cnt) || bus.sleep_cycles !== 32'(m_sleep_cnt)) begin
            failures++;
            $display("FAIL stats run=%0d want=%0d sleep=%0d want=%0d", bus.run_cycles, m_run_cnt,
                     bus.sleep_cycles, m_sleep_cnt);
        end
        finish_run();
    endtask
`endif

    task automatic test_reset_mid_run();
        do_start(1'b0);
        for (int i = 0; i < 6; i++) run_cycle(~i[0], 1'b0, 1'b0);
        checks++;
        if (bus.sync_rounds !== RW'(3)) begin
            failures++; $display("FAIL midrun_rounds sync_rounds=%0d want=3", bus.sync_rounds);
        end
        #2;
        rst_n = 1'b0;
        m_in_run = 1'b0;
        bus.trig_idle = '1;
        #1;
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.trig_start !== '0 || bus.sync_rounds !== RW'(m_rounds)) begin
            failures++;
            $display("FAIL midrun_reset ap_idle=%b trig_start=%b sync_rounds=%0d want 1/0/%0d", bus.ap_idle,
                     bus.trig_start, bus.sync_rounds, m_rounds);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin
                failures++; $display("FAIL midrun_nodone ap_done=%b ap_idle=%b want 0/1", bus.ap_done, bus.ap_idle);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_in_run = 1'b0;
        m_clr = 1'b0;
        bus.ap_start = 1'b0;
        idle_inputs();
        test_reset();
        test_qualifiers();
        test_start_and_rounds();
        test_back_to_back();
        test_random_runs();
`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
        test_stats();
`endif
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
